// File: rtl/fetch_unit.sv
// Instruction fetch front-end: PC generation, 1-cycle-latency imem requests, PC/insn FIFO, redirect flush.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        insn_valid,
  input  logic        insn_ready,
  output logic [31:0] insn,
  output logic [31:0] insn_pc,
  output logic        insn_fault
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_V = DEPTH[CW:0];
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  logic [31:0]   fpc_reg;
  logic          inflight_reg;
  logic [31:0]   req_pc_reg;
  logic          req_epoch_reg;
  logic          epoch_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [31:0]   data_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic          halted;
  logic          push;
  logic          pop;
  logic [CW:0]   occupancy;
  logic [31:0]   redirect_target;

  // Low redirect bits only matter for the trap; otherwise the target is word aligned.
  assign redirect_target = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
  logic halted_reg;
  logic fault_mem [DEPTH];
  logic misalign_redirect;
  assign halted            = halted_reg;
  assign misalign_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign insn_fault        = fault_mem[rd_ptr_reg];
`else
  logic unused_redirect_low;
  assign unused_redirect_low = &{1'b0, redirect_pc[1:0]};
  assign halted     = 1'b0;
  assign insn_fault = 1'b0;
`endif

  // A request slot is reserved for the in-flight response so the FIFO can never overflow.
  assign occupancy  = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg};
  assign imem_req   = !reset && !redirect_valid && !halted && (occupancy < DEPTH_V);
  assign imem_addr  = fpc_reg;
  assign insn_valid = (count_reg != '0) && !redirect_valid;
  assign insn       = data_mem[rd_ptr_reg];
  assign insn_pc    = pc_mem[rd_ptr_reg];
  assign pop        = insn_valid && insn_ready;
  // A redirect this cycle already advances the epoch, so the returning response is stale.
  assign push       = inflight_reg && (req_epoch_reg == (epoch_reg ^ redirect_valid));

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_reg       <= RESET_PC;
      inflight_reg  <= 1'b0;
      req_pc_reg    <= '0;
      req_epoch_reg <= 1'b0;
      epoch_reg     <= 1'b0;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_mem[i] <= 1'b0;
`endif
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      halted_reg <= 1'b0;
`endif
    end else begin
      inflight_reg <= imem_req;
      if (imem_req) begin
        fpc_reg       <= fpc_reg + 32'd4;
        req_pc_reg    <= fpc_reg;
        req_epoch_reg <= epoch_reg;
      end

      if (redirect_valid) begin
        epoch_reg  <= ~epoch_reg;
        fpc_reg    <= redirect_target;
        rd_ptr_reg <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
        halted_reg <= misalign_redirect;
        if (misalign_redirect) begin
          data_mem[0]  <= NOP_INSN;
          pc_mem[0]    <= redirect_pc;
          fault_mem[0] <= 1'b1;
          wr_ptr_reg   <= PW'(1);
          count_reg    <= CW'(1);
        end else begin
          wr_ptr_reg <= '0;
          count_reg  <= '0;
        end
`else
        wr_ptr_reg <= '0;
        count_reg  <= '0;
`endif
      end else begin
        if (push) begin
          data_mem[wr_ptr_reg] <= imem_rdata;
          pc_mem[wr_ptr_reg]   <= req_pc_reg;
`ifdef FETCH_MISALIGN_TRAP_EN
          fault_mem[wr_ptr_reg] <= 1'b0;
`endif
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
        if (push && !pop) begin
          count_reg <= count_reg + 1'b1;
        end else if (!push && pop) begin
          count_reg <= count_reg - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed latency/redirect/reset scenarios plus a random stream
// checked against a sequential-PC reference model. Honours FETCH_MISALIGN_TRAP_EN like the design.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn;
  logic [31:0] insn_pc;
  logic        insn_fault;

  logic [31:0] mem [256];
  logic [31:0] plan_words [3];
  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .insn_valid(insn_valid), .insn_ready(insn_ready),
    .insn(insn), .insn_pc(insn_pc), .insn_fault(insn_fault)
  );

  // Synchronous instruction memory, one-cycle read latency.
  always @(posedge clk) if (imem_req) imem_rdata <= mem[imem_addr[9:2]];

  function automatic logic [31:0] ref_insn(input logic [31:0] pc);
    return mem[pc[9:2]];
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic apply_reset();
    next_cycle();
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; insn_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    next_cycle();
    settle();
    total_cnt++;
    if ({imem_req, insn_valid, insn_fault} !== 3'b000)
      $display("FAIL reset_ctrl: req/valid/fault=%b expected 000", {imem_req, insn_valid, insn_fault});
    else pass_cnt++;
    total_cnt++;
    if ({insn, insn_pc} !== 64'h0)
      $display("FAIL reset_data: insn=%h pc=%h expected 0/0", insn, insn_pc);
    else pass_cnt++;
  endtask

  task automatic test_startup();
    apply_reset();
    for (int c = 0; c <= 4; c++) begin
      next_cycle(); reset = 1'b0; insn_ready = 1'b1; settle();
      if (c == 0) begin
        total_cnt++;
        if ({imem_req, imem_addr} !== {1'b1, RESET_PC})
          $display("FAIL startup_req: req=%b addr=%h expected 1/%h", imem_req, imem_addr, RESET_PC);
        else pass_cnt++;
      end
      if (c < 2) begin
        total_cnt++;
        if (insn_valid !== 1'b0) $display("FAIL startup_early c%0d: valid=%b expected 0", c, insn_valid);
        else pass_cnt++;
      end else begin
        total_cnt++;
        if ({insn_valid, insn_pc, insn} !== {1'b1, 32'((c - 2) * 4), plan_words[c - 2]})
          $display("FAIL startup_insn c%0d: valid=%b pc=%h insn=%h expected 1/%h/%h",
                   c, insn_valid, insn_pc, insn, 32'((c - 2) * 4), plan_words[c - 2]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int c = 0; c <= 7; c++) begin
      next_cycle(); reset = 1'b0; insn_ready = 1'b0; settle();
      if (c >= 2) begin
        total_cnt++;
        if ({insn_valid, insn_pc} !== {1'b1, 32'h0})
          $display("FAIL hold_head c%0d: valid=%b pc=%h expected 1/0", c, insn_valid, insn_pc);
        else pass_cnt++;
      end
      if (c >= 5) begin
        total_cnt++;
        if (imem_req !== 1'b0) $display("FAIL full_no_req c%0d: req=%b expected 0", c, imem_req);
        else pass_cnt++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      next_cycle(); insn_ready = 1'b1; settle();
      total_cnt++;
      if ({insn_valid, insn_pc, insn} !== {1'b1, 32'(k * 4), ref_insn(32'(k * 4))})
        $display("FAIL drain k%0d: valid=%b pc=%h insn=%h expected 1/%h/%h",
                 k, insn_valid, insn_pc, insn, 32'(k * 4), ref_insn(32'(k * 4)));
      else pass_cnt++;
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    for (int c = 0; c <= 3; c++) begin
      next_cycle(); reset = 1'b0; insn_ready = 1'b1; settle();
    end
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h40; settle();
    total_cnt++;
    if ({insn_valid, imem_req} !== 2'b00)
      $display("FAIL redir_R: valid=%b req=%b expected 0/0", insn_valid, imem_req);
    else pass_cnt++;
    next_cycle(); redirect_valid = 1'b0; settle();
    total_cnt++;
    if ({imem_req, imem_addr, insn_valid} !== {1'b1, 32'h40, 1'b0})
      $display("FAIL redir_R1: req=%b addr=%h valid=%b expected 1/40/0", imem_req, imem_addr, insn_valid);
    else pass_cnt++;
    next_cycle(); settle();
    total_cnt++;
    if (insn_valid !== 1'b0) $display("FAIL redir_R2: valid=%b expected 0", insn_valid);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin next_cycle(); settle(); end
      else begin next_cycle(); settle(); end
      total_cnt++;
      if ({insn_valid, insn_pc, insn} !== {1'b1, 32'h40 + 32'(k * 4), ref_insn(32'h40 + 32'(k * 4))})
        $display("FAIL redir_stream k%0d: valid=%b pc=%h insn=%h expected 1/%h",
                 k, insn_valid, insn_pc, insn, 32'h40 + 32'(k * 4));
      else pass_cnt++;
    end
  endtask

  task automatic test_redirect_pop();
    logic [31:0] tgt;
    int wait_cycles;
    tgt = 32'($urandom_range(8, 255)) << 2;
    apply_reset();
    for (int c = 0; c <= 2; c++) begin
      next_cycle(); reset = 1'b0; insn_ready = 1'b1; settle();
    end
    next_cycle(); redirect_valid = 1'b1; redirect_pc = tgt; insn_ready = 1'b1; settle();
    total_cnt++;
    if (insn_valid !== 1'b0) $display("FAIL redir_pop_valid: valid=%b expected 0", insn_valid);
    else pass_cnt++;
    wait_cycles = 0;
    do begin
      next_cycle(); redirect_valid = 1'b0; settle();
      wait_cycles++;
    end while (!insn_valid && wait_cycles < 8);
    total_cnt++;
    if ({insn_valid, insn_pc} !== {1'b1, tgt} || wait_cycles != 3)
      $display("FAIL redir_pop_next: valid=%b pc=%h after %0d cycles expected 1/%h after 3",
               insn_valid, insn_pc, wait_cycles, tgt);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] tgt_a, tgt_b;
    int wait_cycles;
    tgt_a = 32'($urandom_range(0, 127)) << 2;
    tgt_b = 32'($urandom_range(128, 255)) << 2;
    apply_reset();
    for (int c = 0; c <= 3; c++) begin
      next_cycle(); reset = 1'b0; insn_ready = 1'b1; settle();
    end
    next_cycle(); redirect_valid = 1'b1; redirect_pc = tgt_a; settle();
    next_cycle(); redirect_valid = 1'b1; redirect_pc = tgt_b; settle();
    total_cnt++;
    if (imem_req !== 1'b0) $display("FAIL b2b_req: req=%b expected 0", imem_req);
    else pass_cnt++;
    next_cycle(); redirect_valid = 1'b0; settle();
    total_cnt++;
    if ({imem_req, imem_addr} !== {1'b1, tgt_b})
      $display("FAIL b2b_addr: req=%b addr=%h expected 1/%h", imem_req, imem_addr, tgt_b);
    else pass_cnt++;
    wait_cycles = 1;
    while (!insn_valid && wait_cycles < 8) begin
      next_cycle(); settle();
      wait_cycles++;
    end
    total_cnt++;
    if ({insn_valid, insn_pc, insn} !== {1'b1, tgt_b, ref_insn(tgt_b)} || wait_cycles != 3)
      $display("FAIL b2b_first: valid=%b pc=%h after %0d cycles expected 1/%h after 3",
               insn_valid, insn_pc, wait_cycles, tgt_b);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int c = 0; c <= 3; c++) begin
      next_cycle(); reset = 1'b0; insn_ready = 1'b0; settle();
    end
    next_cycle(); settle();
    total_cnt++;
    if ({insn_valid, insn_pc} !== {1'b1, 32'h0})
      $display("FAIL mid_pre: valid=%b pc=%h expected 1/0", insn_valid, insn_pc);
    else pass_cnt++;
    reset = 1'b1;
    next_cycle(); reset = 1'b0; insn_ready = 1'b1; settle();
    total_cnt++;
    if ({insn_valid, imem_req, imem_addr} !== {1'b0, 1'b1, RESET_PC})
      $display("FAIL mid_after: valid=%b req=%b addr=%h expected 0/1/%h", insn_valid, imem_req, imem_addr, RESET_PC);
    else pass_cnt++;
    next_cycle(); settle();
    total_cnt++;
    if (insn_valid !== 1'b0) $display("FAIL mid_c1: valid=%b expected 0", insn_valid);
    else pass_cnt++;
    next_cycle(); settle();
    total_cnt++;
    if ({insn_valid, insn_pc, insn} !== {1'b1, RESET_PC, plan_words[0]})
      $display("FAIL mid_c2: valid=%b pc=%h insn=%h expected 1/%h/%h", insn_valid, insn_pc, insn, RESET_PC, plan_words[0]);
    else pass_cnt++;
  endtask

  task automatic test_misalign();
    apply_reset();
    for (int c = 0; c <= 3; c++) begin
      next_cycle(); reset = 1'b0; insn_ready = 1'b1; settle();
    end
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h42; insn_ready = 1'b0; settle();
`ifdef FETCH_MISALIGN_TRAP_EN
    next_cycle(); redirect_valid = 1'b0; settle();
    total_cnt++;
    if ({insn_valid, insn_pc, insn_fault, insn, imem_req} !== {1'b1, 32'h42, 1'b1, 32'h13, 1'b0})
      $display("FAIL trap_entry: valid=%b pc=%h fault=%b insn=%h req=%b expected 1/42/1/13/0",
               insn_valid, insn_pc, insn_fault, insn, imem_req);
    else pass_cnt++;
    next_cycle(); insn_ready = 1'b1; settle();
    for (int k = 0; k < 5; k++) begin
      next_cycle(); settle();
      total_cnt++;
      if ({imem_req, insn_valid} !== 2'b00)
        $display("FAIL trap_halted k%0d: req=%b valid=%b expected 0/0", k, imem_req, insn_valid);
      else pass_cnt++;
    end
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h80; settle();
    next_cycle(); redirect_valid = 1'b0; settle();
    total_cnt++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h80})
      $display("FAIL trap_exit_req: req=%b addr=%h expected 1/80", imem_req, imem_addr);
    else pass_cnt++;
    next_cycle(); settle();
    next_cycle(); settle();
    total_cnt++;
    if ({insn_valid, insn_pc, insn_fault, insn} !== {1'b1, 32'h80, 1'b0, ref_insn(32'h80)})
      $display("FAIL trap_exit_insn: valid=%b pc=%h fault=%b expected 1/80/0", insn_valid, insn_pc, insn_fault);
    else pass_cnt++;
`else
    next_cycle(); redirect_valid = 1'b0; insn_ready = 1'b1; settle();
    total_cnt++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h40})
      $display("FAIL trunc_req: req=%b addr=%h expected 1/40", imem_req, imem_addr);
    else pass_cnt++;
    next_cycle(); settle();
    next_cycle(); settle();
    total_cnt++;
    if ({insn_valid, insn_pc, insn_fault, insn} !== {1'b1, 32'h40, 1'b0, ref_insn(32'h40)})
      $display("FAIL trunc_insn: valid=%b pc=%h fault=%b insn=%h expected 1/40/0/%h",
               insn_valid, insn_pc, insn_fault, insn, ref_insn(32'h40));
    else pass_cnt++;
`endif
  endtask

  // Reference: delivered PCs form a +4 sequence restarting at each redirect target.
  task automatic test_random_stream();
    logic [31:0] exp_pc, prev_pc, tgt;
    logic prev_hold, redir;
    int deliveries;
    exp_pc = RESET_PC; prev_pc = 32'h0; prev_hold = 1'b0; deliveries = 0;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      next_cycle();
      reset = 1'b0;
      redir = ($urandom_range(0, 99) < 4);
`ifdef FETCH_MISALIGN_TRAP_EN
      tgt = 32'($urandom_range(0, 1023)) << 2;
`else
      tgt = 32'($urandom_range(0, 4095));
`endif
      redirect_valid = redir;
      redirect_pc = tgt;
      insn_ready = ($urandom_range(0, 99) < 70);
      settle();
      if (prev_hold && !redir) begin
        total_cnt++;
        if ({insn_valid, insn_pc} !== {1'b1, prev_pc})
          $display("FAIL rnd_stable c%0d: valid=%b pc=%h expected 1/%h", c, insn_valid, insn_pc, prev_pc);
        else pass_cnt++;
      end
      if (redir) begin
        total_cnt++;
        if (insn_valid !== 1'b0) $display("FAIL rnd_redir_valid c%0d: valid=%b expected 0", c, insn_valid);
        else pass_cnt++;
        exp_pc = tgt & ~32'h3;
      end else if (insn_valid && insn_ready) begin
        total_cnt++;
        if ({insn_pc, insn, insn_fault} !== {exp_pc, ref_insn(exp_pc), 1'b0})
          $display("FAIL rnd_deliver c%0d: pc=%h insn=%h fault=%b expected %h/%h/0",
                   c, insn_pc, insn, insn_fault, exp_pc, ref_insn(exp_pc));
        else pass_cnt++;
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end
      prev_hold = insn_valid && !insn_ready && !redir;
      prev_pc = insn_pc;
    end
    total_cnt++;
    if (deliveries < 150) $display("FAIL rnd_throughput: delivered=%0d expected >=150", deliveries);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; insn_ready = 1'b0;
    plan_words[0] = 32'h02A08093;
    plan_words[1] = 32'h03510113;
    plan_words[2] = 32'h0020C1B3;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int i = 0; i < 3; i++) mem[i] = plan_words[i];

    test_reset();
    test_startup();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_back_to_back();
    test_reset_mid();
    test_misalign();
    test_random_stream();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front-end for the rv32i core; sits between the instruction memory and the core's decode/execute stage.
- Generates the fetch PC and issues word reads to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions, paired with their PCs, in a small FIFO.
- Presents them downstream over a valid/ready handshake, and handles PC redirects from branches/jumps by flushing the FIFO.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- DEPTH, 4, FIFO entries; power of 2, >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  read request this cycle.
- imem_addr  output  32  byte address of the request; word aligned.
- imem_rdata  input  32  read data, valid the cycle after imem_req=1.
- redirect_valid  input  1  load a new fetch PC.
- redirect_pc  input  32  target of the redirect.
- insn_valid  output  1  FIFO head holds a valid instruction.
- insn_ready  input  1  consumer accepts the head this cycle.
- insn  output  32  head instruction word.
- insn_pc  output  32  byte address of the head instruction.
- insn_fault  output  1  head is a misaligned-fetch fault (only with the optional feature; tied 0 otherwise).

Behaviour:
- Reset (sync, active-high), applied on the clock edge:
  - fpc = RESET_PC; FIFO empty; in-flight flag cleared.
  - Outputs: imem_req=0, insn_valid=0, insn=0, insn_pc=0, insn_fault=0.
- Reset asserted mid-operation:
  - Discards all FIFO entries.
  - Discards any response returning in the cycle after reset.
- Request issue:
  - imem_req = !reset && !redirect_valid && !halted && (count + inflight < DEPTH).
  - imem_addr = fpc.
  - On issue: fpc <= fpc + 4, wrapping modulo 2^32; inflight <= 1. Otherwise inflight <= 0.
- Response capture:
  - If inflight=1 and the epoch matches, imem_rdata and the request PC are written at the FIFO tail on the next edge.
  - Each response is tagged with a 1-bit epoch, toggled on every redirect. A mismatching response is dropped.
- Head output:
  - insn_valid = (count != 0) && !redirect_valid.
  - insn, insn_pc and insn_fault come from the head entry, driven from registers. They hold stable while insn_valid && !insn_ready.
- Pop: on insn_valid && insn_ready the head is removed. Push and pop may occur in the same cycle; count is unchanged.
- Pointers: read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. count ranges 0..DEPTH.
  - Full: count+inflight=DEPTH, so no issue. No push can ever overflow.
  - Empty: insn_valid=0.
- Latency:
  - First request in the cycle after reset deasserts (cycle 0, addr RESET_PC).
  - insn_valid high in cycle 2.
  - Steady state: 1 instruction/cycle when insn_ready=1.
- Redirect (cycle R):
  - FIFO flushed; epoch toggled; fpc <= redirect_pc; no request in cycle R.
  - Redirect has priority over a simultaneous pop: the head is flushed, not consumed.
  - Next request in R+1 at redirect_pc; first new instruction valid in R+3.
  - Back-to-back redirects: the last one wins.
- Without the optional feature, redirect_pc[1:0] is ignored (forced to 00).

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined: a redirect with redirect_pc[1:0] != 0 does not fetch.
  - Instead it pushes one entry: insn=32'h0000_0013 (NOP), insn_pc=redirect_pc, insn_fault=1.
  - The unit then enters a halted state: imem_req stays 0.
  - Exit: the next aligned redirect, or reset.
- Not defined: insn_fault is tied 0 and the halted state does not exist. redirect_pc is truncated to word alignment.

Test Plan:
1. Memory model: mem[0]=32'h02A08093, mem[1]=32'h03510113, mem[2]=32'h0020C1B3. Release reset with insn_ready=1 -> insn_valid in cycle 2 with insn=02A08093/pc=0, then 03510113/pc=4 and 0020C1B3/pc=8 on consecutive cycles.
2. insn_ready=0 from cycle 2 -> FIFO holds 4 entries, imem_req=0, and head holds pc=0 stable. Raise insn_ready -> pcs 0,4,8,12,16 in order with no gaps or duplicates.
3. Redirect to 32'h40 while a request is in flight -> no instruction from the old stream appears after R. In R+3: insn_valid=1, insn_pc=32'h40.
4. insn_valid=1, insn_ready=1 and redirect_valid=1 in the same cycle -> head not consumed. The next delivered pc equals redirect_pc.
5. Reset pulsed for one cycle mid-stream with the FIFO at 3 entries -> insn_valid=0 next cycle, and the stream restarts at RESET_PC with pc=0 valid 2 cycles after release.
6. With FETCH_MISALIGN_TRAP_EN, redirect to 32'h42 -> one entry with pc=32'h42, insn_fault=1; imem_req stays 0 until an aligned redirect to 32'h80, after which pc=32'h80 is delivered. Without the macro, the same redirect fetches from 32'h40.
